// File: rtl/gouram_query_pkg.sv
// Shared definitions for the trace query arbiter.
//   query_state_t : arbiter FSM encoding
//   NO_HIT_TIME   : timestamp value meaning "no match" (-1)
//   query_range_t : packed {start,end} time window at the default timestamp width
package gouram_query_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } query_state_t;

  localparam int QUERY_TIME_W = 32;

  localparam logic signed [QUERY_TIME_W-1:0] NO_HIT_TIME = -1;

  typedef struct packed {
    logic signed [QUERY_TIME_W-1:0] range_start;
    logic signed [QUERY_TIME_W-1:0] range_end;
  } query_range_t;

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// after rr_ptr, wrapping modulo NUM_REQ.
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  PTR_W    search start index (always < NUM_REQ)
//   grant_idx out PTR_W    chosen index (0 when nothing is requested)
//   any_req   out 1        at least one request bit set
module rr_grant_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [PTR_W:0] cand;

  // Walk offsets from the far end down to 0 so the last hit written is the
  // one closest to rr_ptr; avoids a loop break.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (req[cand[PTR_W-1:0]]) begin
        grant_idx = cand[PTR_W-1:0];
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_query_arbiter.sv
// Shares one history-buffer query port among NUM_REQ tracker requesters.
// Round-robin arbitration, latches the winner's window, runs the recalc
// handshake with the shared tracker, then strobes the result back to the
// winner only.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_i[NUM_REQ]         level request, held until own rsp_valid_o bit
//   range_start_i/_end_i   packed per-requester windows (slot k = [k*TW +: TW])
//   rsp_valid_o[NUM_REQ]   one-hot single-cycle response strobe
//   rsp_hit_o/_time_o      broadcast result, qualified by rsp_valid_o
//   rsp_timeout_o          broadcast, response produced by the watchdog
//   trk_range_o            {end,start} to the shared tracker
//   trk_recalc_o           single-cycle query strobe to the tracker
//   trk_done_i/_hit_i/_time_i  tracker result
//   busy_o                 high whenever not IDLE
//
// Optional build macro GOURAM_QUERY_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles; without it WAIT waits forever and rsp_timeout_o = 0.
//
// state   | meaning
// IDLE    | arbitrate; latch winner index and window
// ISSUE   | pulse trk_recalc_o, or skip tracker on start > end
// WAIT    | hold trk_range_o until trk_done_i (or watchdog)
// RESPOND | strobe rsp_valid_o[grant], advance rr_ptr
module trace_query_arbiter
  import gouram_query_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIME_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] range_start_i,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] range_end_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic                          rsp_hit_o,
  output logic [TIME_WIDTH-1:0]         rsp_time_o,
  output logic                          rsp_timeout_o,
  output logic [2*TIME_WIDTH-1:0]       trk_range_o,
  output logic                          trk_recalc_o,
  input  logic                          trk_done_i,
  input  logic                          trk_hit_i,
  input  logic [TIME_WIDTH-1:0]         trk_time_i,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic signed [TIME_WIDTH-1:0] NO_HIT = TIME_WIDTH'(NO_HIT_TIME);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("trace_query_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("trace_query_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  query_state_t state, state_nxt;

  logic [PTR_W-1:0]             rr_ptr, grant_q, pick_idx;
  logic                         pick_any;
  logic signed [TIME_WIDTH-1:0] start_q, end_q, time_q;
  logic                         hit_q;
  logic                         degenerate;
  logic                         wd_expired;

  logic [TIME_WIDTH-1:0] start_arr [NUM_REQ];
  logic [TIME_WIDTH-1:0] end_arr   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign start_arr[k] = range_start_i[k*TIME_WIDTH +: TIME_WIDTH];
    assign end_arr[k]   = range_end_i[k*TIME_WIDTH +: TIME_WIDTH];
  end

  rr_grant_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (req_i),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  assign degenerate = (start_q > end_q);

`ifdef GOURAM_QUERY_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Down-counter loaded on the way into WAIT; terminal count 0 after
  // TIMEOUT_CYCLES cycles spent in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (state == WAIT && wd_cnt != '0) begin
      wd_cnt <= wd_cnt - WD_W'(1);
    end
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (state == ISSUE) begin
      timeout_q <= 1'b0;
    end else if (state == WAIT && !trk_done_i && wd_expired) begin
      timeout_q <= 1'b1;
    end
  end

  assign rsp_timeout_o = timeout_q;
`else
  assign wd_expired    = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rsp_valid_o  = '0;
    trk_recalc_o = 1'b0;
    busy_o       = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (degenerate) begin
          state_nxt = RESPOND;
        end else begin
          trk_recalc_o = 1'b1;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        // trk_done_i takes priority over a same-cycle watchdog expiry.
        if (trk_done_i || wd_expired) state_nxt = RESPOND;
      end
      RESPOND: begin
        rsp_valid_o[grant_q] = 1'b1;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      start_q <= '0;
      end_q   <= '0;
      hit_q   <= 1'b0;
      time_q  <= NO_HIT;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            start_q <= start_arr[pick_idx];
            end_q   <= end_arr[pick_idx];
          end
        end
        ISSUE: begin
          if (degenerate) begin
            hit_q  <= 1'b0;
            time_q <= NO_HIT;
          end
        end
        WAIT: begin
          if (trk_done_i) begin
            hit_q  <= trk_hit_i;
            time_q <= trk_time_i;
          end else if (wd_expired) begin
            hit_q  <= 1'b0;
            time_q <= NO_HIT;
          end
        end
        RESPOND: begin
          rr_ptr <= (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_hit_o   = hit_q;
  assign rsp_time_o  = time_q;
  assign trk_range_o = {end_q, start_q};

`ifndef SYNTHESIS
  // A requester dropping req_i mid-query does not cancel it; flag it.
  req_held_a: assert property (@(posedge clk) disable iff (rst)
    (state == ISSUE || state == WAIT) |-> req_i[grant_q]);
`endif

endmodule

// File: tb/tb_trace_query_arbiter.sv
// Directed bench for trace_query_arbiter with a response scoreboard: the
// stimulus pushes expected responses, a monitor pops and compares on every
// rsp_valid_o strobe. A small tracker model answers trk_recalc_o.
module tb_trace_query_arbiter;

  localparam int NR = 3;
  localparam int TW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_i;
  logic [NR*TW-1:0]  range_start_i;
  logic [NR*TW-1:0]  range_end_i;
  logic [NR-1:0]     rsp_valid_o;
  logic              rsp_hit_o;
  logic [TW-1:0]     rsp_time_o;
  logic              rsp_timeout_o;
  logic [2*TW-1:0]   trk_range_o;
  logic              trk_recalc_o;
  logic              trk_done_i;
  logic              trk_hit_i;
  logic [TW-1:0]     trk_time_i;
  logic              busy_o;

  trace_query_arbiter #(
    .NUM_REQ        (NR),
    .TIME_WIDTH     (TW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .range_start_i (range_start_i),
    .range_end_i   (range_end_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_hit_o     (rsp_hit_o),
    .rsp_time_o    (rsp_time_o),
    .rsp_timeout_o (rsp_timeout_o),
    .trk_range_o   (trk_range_o),
    .trk_recalc_o  (trk_recalc_o),
    .trk_done_i    (trk_done_i),
    .trk_hit_i     (trk_hit_i),
    .trk_time_i    (trk_time_i),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        hit;
    logic [31:0] t;
    logic        to;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int rsp_seen = 0;
  int recalc_cnt = 0;
  logic [63:0] last_range = '0;

  // tracker model controls (written only by the main process)
  logic        trk_silent = 1'b0;
  int          trk_lat = 1;
  logic        trk_hit_cfg = 1'b0;
  logic [31:0] trk_time_cfg = '0;
  logic        trk_offset_mode = 1'b0;
  int          manual_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic hit, input int t, input logic to);
    exp_t e;
    e.idx = idx;
    e.hit = hit;
    e.t   = t;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic set_range(input int k, input int s, input int e);
    range_start_i[k*TW +: TW] = s;
    range_end_i[k*TW +: TW]   = e;
  endtask

  // n counts negedges inclusive of the cycle in which the request is first
  // visible in IDLE, so a response in that cycle's second successor gives 3.
  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid_o == '0 && n < limit);
    if (rsp_valid_o == '0) begin
      total++;
      bad++;
      $display("FAIL rsp_wait_timeout: got no response in %0d cycles, required one", limit);
    end
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    logic [NR-1:0] ev;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid_o != '0) begin
        rsp_seen++;
        check("rsp_onehot", 64'($onehot(rsp_valid_o)), 64'd1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got valid=%b required none", rsp_valid_o);
        end else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.idx] = 1'b1;
          check("rsp_valid", 64'(rsp_valid_o), 64'(ev));
          check("rsp_hit", 64'(rsp_hit_o), 64'(e.hit));
          check("rsp_time", 64'(rsp_time_o), 64'(e.t));
          check("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
        end
      end
    end
  end

  // recalc pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (trk_recalc_o) begin
        recalc_cnt++;
        last_range = trk_range_o;
      end
    end
  end

  // tracker model: answers recalc after trk_lat cycles, or emits a stray
  // done pulse when manual_cnt is bumped
  initial begin
    logic [63:0] r;
    int manual_seen;
    manual_seen = 0;
    trk_done_i = 1'b0;
    trk_hit_i  = 1'b0;
    trk_time_i = '0;
    forever begin
      @(negedge clk);
      if (trk_recalc_o && !trk_silent) begin
        r = trk_range_o;
        repeat (trk_lat) @(posedge clk);
        #1;
        trk_done_i = 1'b1;
        trk_hit_i  = trk_hit_cfg;
        trk_time_i = trk_offset_mode ? r[31:0] + 32'd4 : trk_time_cfg;
        @(posedge clk);
        #1;
        trk_done_i = 1'b0;
        trk_hit_i  = 1'b0;
        trk_time_i = '0;
      end else if (manual_cnt != manual_seen) begin
        manual_seen = manual_cnt;
        @(posedge clk);
        #1;
        trk_done_i = 1'b1;
        trk_hit_i  = 1'b1;
        trk_time_i = 32'd99;
        @(posedge clk);
        #1;
        trk_done_i = 1'b0;
        trk_hit_i  = 1'b0;
        trk_time_i = '0;
      end
    end
  end

  initial begin
    int n;
    int base;
    int seen0;
    rst = 1'b0;
    req_i = '0;
    range_start_i = '0;
    range_end_i = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_hit", 64'(rsp_hit_o), 64'd0);
    check("rst_rsp_time", 64'(rsp_time_o), 64'hFFFF_FFFF);
    check("rst_rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    check("rst_trk_range", trk_range_o, 64'd0);
    check("rst_trk_recalc", 64'(trk_recalc_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fairness: all three held, tracker returns start+4 after 1 cycle
    trk_offset_mode = 1'b1;
    trk_lat = 1;
    trk_hit_cfg = 1'b1;
    set_range(0, 40, 50);
    set_range(1, 50, 60);
    set_range(2, 60, 70);
    push_exp(0, 1'b1, 44, 1'b0);
    push_exp(1, 1'b1, 54, 1'b0);
    push_exp(2, 1'b1, 64, 1'b0);
    push_exp(0, 1'b1, 44, 1'b0);
    req_i = 3'b111;
    for (int i = 0; i < 4; i++) wait_rsp(50, n);
    @(posedge clk);
    #1 req_i = '0;

    // single request from requester 1, tracker latency 2 (rr_ptr now 1)
    trk_offset_mode = 1'b0;
    trk_lat = 2;
    trk_hit_cfg = 1'b1;
    trk_time_cfg = 32'd14;
    set_range(1, 10, 20);
    base = recalc_cnt;
    push_exp(1, 1'b1, 14, 1'b0);
    req_i = 3'b010;
    wait_rsp(50, n);
    check("single_latency", 64'(n), 64'd5);
    check("single_recalc_cnt", 64'(recalc_cnt - base), 64'd1);
    check("single_trk_range", last_range, {32'd20, 32'd10});
    @(posedge clk);
    #1 req_i = '0;

    // degenerate window from requester 2: no tracker query
    set_range(2, 30, 25);
    base = recalc_cnt;
    push_exp(2, 1'b0, -1, 1'b0);
    req_i = 3'b100;
    wait_rsp(50, n);
    check("degen_latency", 64'(n), 64'd3);
    check("degen_recalc_cnt", 64'(recalc_cnt - base), 64'd0);
    @(posedge clk);
    #1 req_i = '0;

    // stray trk_done_i while IDLE
    seen0 = rsp_seen;
    base = recalc_cnt;
    manual_cnt++;
    repeat (5) @(negedge clk);
    check("idle_done_rsp", 64'(rsp_seen - seen0), 64'd0);
    check("idle_done_busy", 64'(busy_o), 64'd0);
    check("idle_done_recalc", 64'(recalc_cnt - base), 64'd0);
    @(posedge clk);
    #1;

    // reset during WAIT, then a late trk_done_i
    trk_silent = 1'b1;
    set_range(0, 5, 9);
    seen0 = rsp_seen;
    req_i = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    check("wait_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_rsp_time", 64'(rsp_time_o), 64'hFFFF_FFFF);
    check("midrst_trk_range", trk_range_o, 64'd0);
    req_i = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    manual_cnt++;
    repeat (5) @(negedge clk);
    check("midrst_no_rsp", 64'(rsp_seen - seen0), 64'd0);
    check("midrst_idle", 64'(busy_o), 64'd0);

    // next request served normally (rr_ptr back to 0)
    trk_silent = 1'b0;
    trk_lat = 1;
    trk_hit_cfg = 1'b1;
    trk_time_cfg = 32'd7;
    push_exp(0, 1'b1, 7, 1'b0);
    @(posedge clk);
    #1 req_i = 3'b001;
    wait_rsp(50, n);
    check("post_rst_latency", 64'(n), 64'd4);
    @(posedge clk);
    #1 req_i = '0;

`ifdef GOURAM_QUERY_TIMEOUT_EN
    // silent tracker: watchdog answers after 8 WAIT cycles
    trk_silent = 1'b1;
    set_range(1, 1, 2);
    push_exp(1, 1'b0, -1, 1'b1);
    req_i = 3'b010;
    wait_rsp(50, n);
    check("timeout_latency", 64'(n), 64'd11);
    @(posedge clk);
    #1 req_i = '0;
    trk_silent = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
